alu_exec_unit: RTL and testbench

- Sequential execution front-end that serves the 16-bit ALU opcode set to an initiator (decode/issue stage) over a valid/ready request/response handshake.
- Ops 0000–0011 (ADD, SUB, AND, OR) run through the existing combinational ALU and return one cycle after accept.
- Ops 0100/0101 (SHL, SHR) run on an internal iterative 1-bit-per-cycle shifter.
- One request outstanding at a time; the result is held until the initiator consumes it.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_exec_unit_alu.sv | 34 +++
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared ALU definitions used by both the combinational ALU and the execution
// front-end: opcode encodings, FSM state encodings and small opcode-class
// helpers.
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

  // Opcode encodings understood by the execution unit
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Opcodes 0..3 are served by the single-cycle combinational ALU
  function automatic logic isAluOp(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  // Opcodes 4 and 5 are served by the iterative shifter; bit 0 picks direction
  function automatic logic isShiftOp(input logic [3:0] op);
    return (op[3:1] == 3'b010);
  endfunction

endpackage

// File: rtl/alu_exec_unit_alu.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_alu
// Purely combinational ALU for ADD, SUB, AND, OR. Arithmetic wraps modulo
// 2^WIDTH; there is no carry or overflow output. Any other opcode yields 0.
// Ports:
//   A, B    : operands
//   opcode  : 4-bit operation select
//   result  : operation result
// ---------------------------------------------------------------------------
module alu_exec_unit_alu
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result
);

  // Select the operation; unsupported opcodes return zero so the caller never
  // sees stale or undefined data.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Sequential execution front-end serving the 16-bit ALU opcode set over a
// valid/ready request/response handshake. One request is outstanding at a
// time and the response is held until the initiator consumes it.
// Ports:
//   clk, rst               : clock (rising edge), async active-high reset
//   req_valid/req_ready    : request handshake
//   req_a, req_b           : operands (req_b is the shift amount for SHL/SHR)
//   req_op, req_tag        : opcode and initiator tag
//   rsp_valid/rsp_ready    : response handshake
//   rsp_result, rsp_tag    : result and echoed tag
//   rsp_err                : illegal opcode flag
//   busy                   : high whenever the FSM is not idle
//   op_count               : number of responses consumed (wraps)
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_err;
  logic [15:0]      r_opCount;

  logic [WIDTH-1:0] w_aluResult;
  logic [WIDTH-1:0] w_accShift;
  logic [WIDTH-1:0] w_reqShift;
  logic             w_bigShift;
  logic             w_zeroShift;
  logic             w_oneShift;

  alu_exec_unit_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .A      (req_a),
    .B      (req_b),
    .opcode (req_op),
    .result (w_aluResult)
  );

  // Shift-amount classification and the two single-bit shift paths: one for
  // the accumulator while iterating, one applied directly to the request
  // operand at accept time.
  always_comb begin
    w_bigShift  = (req_b > WIDTH'(WIDTH - 1));
    w_zeroShift = (req_b == '0);
    w_oneShift  = (req_b == WIDTH'(1));
    w_accShift  = r_dir     ? (r_acc >> 1) : (r_acc << 1);
    w_reqShift  = req_op[0] ? (req_a >> 1) : (req_a << 1);
  end

  // Handshake and status outputs come straight from the state register;
  // req_ready is held low while reset is asserted.
  always_comb begin
    req_ready  = (r_state == ST_IDLE) && !rst;
    rsp_valid  = (r_state == ST_RESP);
    busy       = (r_state != ST_IDLE);
    rsp_result = r_result;
    rsp_tag    = r_tag;
    rsp_err    = r_err;
    op_count   = r_opCount;
  end

  // Main FSM. The first shift step is applied at the accept edge, so a shift
  // by N spends N-1 cycles in SHIFT and its response appears N cycles after
  // accept, while shifts by 0, 1 or >= WIDTH resolve immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_result  <= '0;
      r_tag     <= '0;
      r_err     <= 1'b0;
      r_opCount <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_tag <= req_tag;
            r_err <= 1'b0;
            if (isAluOp(req_op)) begin
              r_result <= w_aluResult;
              r_state  <= ST_RESP;
            end else if (isShiftOp(req_op)) begin
              if (w_bigShift) begin
                r_result <= '0;
                r_state  <= ST_RESP;
              end else if (w_zeroShift) begin
                r_result <= req_a;
                r_state  <= ST_RESP;
              end else if (w_oneShift) begin
                r_result <= w_reqShift;
                r_state  <= ST_RESP;
              end else begin
                r_acc   <= w_reqShift;
                r_cnt   <= req_b[CNT_W-1:0] - CNT_W'(1);
                r_dir   <= req_op[0];
                r_state <= ST_SHIFT;
              end
            end else begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_accShift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_accShift;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_opCount <= r_opCount + 16'd1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Expected responses are computed by a
// small reference model when a request is issued, queued, and compared when
// the DUT presents its response.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  tag;
    logic        err;
    int          lat;
  } expT;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [15:0] op_count;

  int          totalChecks = 0;
  int          badChecks   = 0;
  logic [15:0] opModel     = '0;
  expT         sbQ[$];

  alu_exec_unit #(
    .WIDTH (16),
    .TAG_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model of one request: result, error flag and latency
  function automatic expT modelOp(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op, input logic [3:0] tag);
    expT e;
    e.tag    = tag;
    e.err    = 1'b0;
    e.lat    = 1;
    e.result = '0;
    case (op)
      4'h0: e.result = a + b;
      4'h1: e.result = a - b;
      4'h2: e.result = a & b;
      4'h3: e.result = a | b;
      4'h4, 4'h5: begin
        if (b >= 16)     e.result = '0;
        else if (b == 0) e.result = a;
        else begin
          e.result = (op == 4'h4) ? (a << b[3:0]) : (a >> b[3:0]);
          e.lat    = int'(b);
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one request, wait for it to be accepted, queue its expectation.
  // Returns just after the accept edge with req_valid dropped.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op, input logic [3:0] tag);
    int n;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("req_ready_timeout", 32'd0, 32'd1);
    sbQ.push_back(modelOp(a, b, op, tag));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, compare it against the queue head,
  // consume it and check the consumed-response counter.
  task automatic collectResponse();
    expT e;
    int  lat;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e   = sbQ.pop_front();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) checkOutput("busy_while_pending", 32'(busy), 32'd1);
    end while (!rsp_valid && lat < 40);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(e.lat));
    checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
    checkOutput("rsp_tag", 32'(rsp_tag), 32'(e.tag));
    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
    checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    opModel = opModel + 16'd1;
    @(negedge clk);
    checkOutput("op_count", 32'(op_count), 32'(opModel));
    checkOutput("rsp_valid_after_consume", 32'(rsp_valid), 32'd0);
  endtask

  // Stimulus table for the straightforward request/response cases
  localparam int NOPS = 11;
  logic [15:0] tblA   [NOPS] = '{16'd10, 16'd50, 16'd20, 16'd85, 16'd12, 16'd48,
                                 16'd1, 16'hABCD, 16'hABCD, 16'h8001, 16'h8001};
  logic [15:0] tblB   [NOPS] = '{16'd20, 16'd30, 16'd50, 16'd170, 16'd2, 16'd2,
                                 16'd15, 16'd0, 16'd16, 16'd1, 16'd1};
  logic [3:0]  tblOp  [NOPS] = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h4, 4'h5,
                                 4'h4, 4'h4, 4'h5, 4'h4, 4'h5};

  initial begin
    expT e;
    logic sawValid;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // Reset state
    #2;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    checkOutput("reset_rsp_result", 32'(rsp_result), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Table-driven ALU and shift cases, each tagged with its index
    for (int i = 0; i < NOPS; i++) begin
      applyStimulus(tblA[i], tblB[i], tblOp[i], 4'(i + 3));
      collectResponse();
    end

    // Backpressure: hold the OR response for 5 cycles while a second request
    // waits on the input side
    applyStimulus(16'd85, 16'd170, 4'h3, 4'd5);
    rsp_ready = 1'b0;
    e = sbQ.pop_front();
    req_a     = 16'd100;
    req_b     = 16'd200;
    req_op    = 4'h0;
    req_tag   = 4'd6;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_result", 32'(rsp_result), 32'(e.result));
      checkOutput("bp_rsp_tag", 32'(rsp_tag), 32'(e.tag));
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    opModel = opModel + 16'd1;
    @(negedge clk);
    checkOutput("bp_op_count", 32'(op_count), 32'(opModel));
    checkOutput("bp_second_req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);
    sbQ.push_back(modelOp(16'd100, 16'd200, 4'h0, 4'd6));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    collectResponse();

    // Illegal opcode
    applyStimulus(16'd7, 16'd3, 4'h7, 4'd12);
    collectResponse();

    // Reset in the middle of a shift
    applyStimulus(16'd1, 16'd10, 4'h4, 4'd9);
    e = sbQ.pop_back();
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    opModel = '0;
    checkOutput("midshift_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midshift_busy", 32'(busy), 32'd0);
    checkOutput("midshift_req_ready", 32'(req_ready), 32'd0);
    checkOutput("midshift_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("midshift_rsp_tag", 32'(rsp_tag), 32'd0);
    checkOutput("midshift_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      sawValid = sawValid | rsp_valid;
    end
    checkOutput("no_rsp_after_reset", 32'(sawValid), 32'd0);
    checkOutput("idle_after_reset", 32'(req_ready), 32'd1);

    applyStimulus(16'd1, 16'd1, 4'h0, 4'd1);
    collectResponse();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
